// File: rtl/fpu_shared_responder.sv
// Shared APU slave: accepts one granted request per cycle and returns ID-tagged results.
// Pipelined ops complete at a fixed LATENCY; DIV is a restoring divider that holds off grant.
module fpu_shared_responder #(
    parameter int NB_CORES         = 9,
    parameter int NB_APU_ARGS      = 2,
    parameter int APU_OPCODE_WIDTH = 5,
    parameter int ID_WIDTH         = NB_CORES,
    parameter int FLAG_WIDTH       = 6,
    parameter int DATA_WIDTH       = 32,
    parameter int LATENCY          = 2
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              data_req_i,
    input  logic [NB_APU_ARGS*DATA_WIDTH-1:0] data_operands_i,
    input  logic [APU_OPCODE_WIDTH-1:0]       data_op_i,
    input  logic [ID_WIDTH-1:0]               data_ID_i,
    input  logic [FLAG_WIDTH-1:0]             data_flag_i,
    output logic                              data_gnt_o,
    output logic                              data_r_valid_o,
    output logic [ID_WIDTH-1:0]               data_r_ID_o,
    output logic [DATA_WIDTH-1:0]             data_r_rdata_o,
    output logic [FLAG_WIDTH-1:0]             data_r_flag_o
);
    localparam int CW = $clog2(DATA_WIDTH + 1);
    localparam logic [APU_OPCODE_WIDTH-1:0] OP_ADD = APU_OPCODE_WIDTH'(0);
    localparam logic [APU_OPCODE_WIDTH-1:0] OP_SUB = APU_OPCODE_WIDTH'(1);
    localparam logic [APU_OPCODE_WIDTH-1:0] OP_MUL = APU_OPCODE_WIDTH'(2);
    localparam logic [APU_OPCODE_WIDTH-1:0] OP_MIN = APU_OPCODE_WIDTH'(3);
    localparam logic [APU_OPCODE_WIDTH-1:0] OP_MAX = APU_OPCODE_WIDTH'(4);
    localparam logic [APU_OPCODE_WIDTH-1:0] OP_DIV = APU_OPCODE_WIDTH'(5);

    if (LATENCY < 1 || LATENCY > DATA_WIDTH + 1) begin : g_bad_latency
        $error("fpu_shared_responder: LATENCY must be 1..DATA_WIDTH+1");
    end
    if (NB_APU_ARGS < 2 || FLAG_WIDTH < 3) begin : g_bad_widths
        $error("fpu_shared_responder: NB_APU_ARGS>=2 and FLAG_WIDTH>=3 required");
    end

    typedef enum logic [1:0] {S_IDLE, S_DIV, S_DONE} state_e;

    state_e                  state_q, state_d;
    logic [DATA_WIDTH-1:0]   rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [ID_WIDTH-1:0]     did_q, did_d;
    logic [DATA_WIDTH-1:0]   op_a, op_b, res;
    logic [FLAG_WIDTH-1:0]   res_flag;
    logic [DATA_WIDTH:0]     trial;
    logic                    accept, is_div, lt;

    logic [LATENCY-1:0]      vld_q;
    logic [ID_WIDTH-1:0]     pid_q [LATENCY];
    logic [DATA_WIDTH-1:0]   pres_q [LATENCY];
    logic [FLAG_WIDTH-1:0]   pflg_q [LATENCY];

    logic unused_inputs;
    assign unused_inputs = ^data_flag_i[FLAG_WIDTH-1:1] ^ ^data_operands_i;

    assign op_a       = data_operands_i[DATA_WIDTH-1:0];
    assign op_b       = data_operands_i[2*DATA_WIDTH-1:DATA_WIDTH];
    assign data_gnt_o = (state_q != S_DIV);
    assign accept     = data_req_i && data_gnt_o;
    assign is_div     = (data_op_i == OP_DIV);
    assign lt         = data_flag_i[0] ? ($signed(op_a) < $signed(op_b)) : (op_a < op_b);

    always_comb begin
        res      = '0;
        res_flag = '0;
        case (data_op_i)
            OP_ADD:  res = op_a + op_b;
            OP_SUB:  res = op_a - op_b;
            OP_MUL:  res = op_a * op_b;
            OP_MIN:  res = lt ? op_a : op_b;
            OP_MAX:  res = lt ? op_b : op_a;
            default: res_flag[1] = 1'b1;
        endcase
        res_flag[2] = (res == '0);
    end

    // Pipelined path: valids reset, payload just rides alongside
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_q <= '0;
        end else begin
            vld_q[0] <= accept && !is_div;
            for (int i = 1; i < LATENCY; i++) vld_q[i] <= vld_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        pid_q[0]  <= data_ID_i;
        pres_q[0] <= res;
        pflg_q[0] <= res_flag;
        for (int i = 1; i < LATENCY; i++) begin
            pid_q[i]  <= pid_q[i-1];
            pres_q[i] <= pres_q[i-1];
            pflg_q[i] <= pflg_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            cnt_q   <= '0;
            did_q   <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dvs_q   <= dvs_d;
            cnt_q   <= cnt_d;
            did_q   <= did_d;
        end
    end

    // quo_q starts as the dividend and is shifted out MSB-first while quotient bits shift in
    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        cnt_d   = cnt_q;
        did_d   = did_q;
        trial   = {rem_q, quo_q[DATA_WIDTH-1]};
        case (state_q)
            S_DIV: begin
                quo_d = quo_q << 1;
                if (trial >= {1'b0, dvs_q}) begin
                    rem_d    = DATA_WIDTH'(trial - {1'b0, dvs_q});
                    quo_d[0] = 1'b1;
                end else begin
                    rem_d    = trial[DATA_WIDTH-1:0];
                end
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(DATA_WIDTH - 1)) state_d = S_DONE;
            end
            default: begin
                state_d = S_IDLE;
                if (accept && is_div) begin
                    state_d = S_DIV;
                    rem_d   = '0;
                    quo_d   = op_a;
                    dvs_d   = op_b;
                    cnt_d   = '0;
                    did_d   = data_ID_i;
                end
            end
        endcase
    end

    always_comb begin
        data_r_valid_o = 1'b0;
        data_r_ID_o    = '0;
        data_r_rdata_o = '0;
        data_r_flag_o  = '0;
        if (state_q == S_DONE) begin
            data_r_valid_o   = 1'b1;
            data_r_ID_o      = did_q;
            data_r_rdata_o   = quo_q;
            data_r_flag_o[0] = (dvs_q == '0);
            data_r_flag_o[2] = (quo_q == '0);
        end else if (vld_q[LATENCY-1]) begin
            data_r_valid_o = 1'b1;
            data_r_ID_o    = pid_q[LATENCY-1];
            data_r_rdata_o = pres_q[LATENCY-1];
            data_r_flag_o  = pflg_q[LATENCY-1];
        end
    end
endmodule

// File: tb/tb_fpu_shared_responder.sv
// Bench for fpu_shared_responder: directed scenarios plus a randomized run scored
// against a cycle-indexed model of expected grants and responses.
module tb_fpu_shared_responder;
    localparam int DW  = 32;
    localparam int LAT = 2;
    localparam int DIVLAT = DW + 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req;
    logic [2*DW-1:0] operands;
    logic [4:0]    op;
    logic [8:0]    id;
    logic [5:0]    flag;
    logic          gnt, rv;
    logic [8:0]    rid;
    logic [DW-1:0] rdata;
    logic [5:0]    rflag;

    int nchk = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    fpu_shared_responder #(.NB_CORES(9), .NB_APU_ARGS(2), .APU_OPCODE_WIDTH(5), .ID_WIDTH(9),
                           .FLAG_WIDTH(6), .DATA_WIDTH(DW), .LATENCY(LAT)) dut (
        .clk(clk), .rst_n(rst_n), .data_req_i(req), .data_operands_i(operands),
        .data_op_i(op), .data_ID_i(id), .data_flag_i(flag), .data_gnt_o(gnt),
        .data_r_valid_o(rv), .data_r_ID_o(rid), .data_r_rdata_o(rdata), .data_r_flag_o(rflag));

    task automatic drive(input logic r, input logic [4:0] o, input logic [DW-1:0] a,
                         input logic [DW-1:0] b, input logic [8:0] i, input logic [5:0] f);
        req = r; op = o; operands = {b, a}; id = i; flag = f;
    endtask

    task automatic nxt;
        @(posedge clk); #1;
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        drive(1'b0, 5'd0, '0, '0, '0, '0);
        nxt();
        rst_n = 1'b1;
    endtask

    // Spec-level result of one operation
    function automatic void ref_op(input logic [4:0] o, input logic [DW-1:0] a, input logic [DW-1:0] b,
                                   input logic sg, output logic [DW-1:0] r, output logic [5:0] f);
        f = '0;
        case (o)
            5'd0: r = a + b;
            5'd1: r = a - b;
            5'd2: r = a * b;
            5'd3: r = sg ? (($signed(a) < $signed(b)) ? a : b) : ((a < b) ? a : b);
            5'd4: r = sg ? (($signed(a) > $signed(b)) ? a : b) : ((a > b) ? a : b);
            5'd5: if (b == 0) begin r = '1; f[0] = 1'b1; end else r = a / b;
            default: begin r = '0; f[1] = 1'b1; end
        endcase
        f[2] = (r == 0);
    endfunction

    task automatic test_reset;
        rst_n = 1'b0;
        drive(1'b1, 5'd0, 32'd1, 32'd2, 9'h1ff, '0);
        nxt();
        nxt();
        @(negedge clk);
        nchk++;
        if (gnt !== 1'b1 || rv !== 1'b0 || rid !== '0 || rdata !== '0 || rflag !== '0) begin
            nerr++;
            $display("FAIL reset_state: got gnt=%b rv=%b id=%h d=%h f=%h, want gnt=1 rest 0",
                     gnt, rv, rid, rdata, rflag);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_add;
        do_reset();
        drive(1'b1, 5'd0, 32'd5, 32'd7, 9'h004, '0);
        @(negedge clk);
        nchk++;
        if (gnt !== 1'b1) begin nerr++; $display("FAIL add_gnt: got %b want 1", gnt); end
        nxt();
        drive(1'b0, 5'd0, '0, '0, '0, '0);
        @(negedge clk);
        nchk++;
        if (rv !== 1'b0) begin nerr++; $display("FAIL add_early: rv got %b want 0", rv); end
        nxt();
        @(negedge clk);
        nchk++;
        if (rv !== 1'b1 || rdata !== 32'd12 || rid !== 9'h004 || rflag !== 6'd0) begin
            nerr++;
            $display("FAIL add_resp: got rv=%b d=%h id=%h f=%h want 1/0000000c/004/00", rv, rdata, rid, rflag);
        end
        nxt();
        @(negedge clk);
        nchk++;
        if (rv !== 1'b0 || rdata !== '0) begin
            nerr++;
            $display("FAIL add_pulse: got rv=%b d=%h want 0/0", rv, rdata);
        end
    endtask

    task automatic test_back_to_back;
        logic [4:0]    ops  [4] = '{5'd1, 5'd2, 5'd3, 5'd4};
        logic [DW-1:0] as   [4] = '{32'd3, 32'h10000, 32'hffffffff, 32'hffffffff};
        logic [DW-1:0] bs   [4] = '{32'd5, 32'h10000, 32'd1, 32'd1};
        logic [5:0]    fl   [4] = '{6'd0, 6'd0, 6'd1, 6'd0};
        logic [DW-1:0] expd [4] = '{32'hfffffffe, 32'd0, 32'hffffffff, 32'hffffffff};
        logic [5:0]    expf [4] = '{6'd0, 6'd4, 6'd0, 6'd0};
        do_reset();
        for (int c = 0; c < 7; c++) begin
            if (c < 4) drive(1'b1, ops[c], as[c], bs[c], 9'(16 + c), fl[c]);
            else       drive(1'b0, 5'd0, '0, '0, '0, '0);
            @(negedge clk);
            nchk++;
            if (c >= LAT && c < LAT + 4) begin
                if (rv !== 1'b1 || rdata !== expd[c-LAT] || rflag !== expf[c-LAT] || rid !== 9'(16 + c - LAT)) begin
                    nerr++;
                    $display("FAIL b2b_resp%0d: got rv=%b d=%h f=%h id=%h want 1/%h/%h/%h", c - LAT,
                             rv, rdata, rflag, rid, expd[c-LAT], expf[c-LAT], 9'(16 + c - LAT));
                end
            end else if (rv !== 1'b0) begin
                nerr++;
                $display("FAIL b2b_idle%0d: rv got %b want 0", c, rv);
            end
            nxt();
        end
    endtask

    task automatic test_div_stall;
        bit add_done = 0;
        logic exp_gnt;
        do_reset();
        for (int c = 0; c < 38; c++) begin
            if (c == 0)         drive(1'b1, 5'd5, 32'd100, 32'd7, 9'h011, '0);
            else if (!add_done) drive(1'b1, 5'd0, 32'd2, 32'd3, 9'h020, '0);
            else                drive(1'b0, 5'd0, '0, '0, '0, '0);
            exp_gnt = (c == 0) || (c >= DIVLAT);
            @(negedge clk);
            nchk++;
            if (gnt !== exp_gnt) begin
                nerr++;
                $display("FAIL div_gnt c%0d: got %b want %b", c, gnt, exp_gnt);
            end
            nchk++;
            if (c == DIVLAT) begin
                if (rv !== 1'b1 || rdata !== 32'd14 || rid !== 9'h011 || rflag !== 6'd0) begin
                    nerr++;
                    $display("FAIL div_resp: got rv=%b d=%h id=%h f=%h want 1/0000000e/011/00", rv, rdata, rid, rflag);
                end
            end else if (c == DIVLAT + LAT) begin
                if (rv !== 1'b1 || rdata !== 32'd5 || rid !== 9'h020 || rflag !== 6'd0) begin
                    nerr++;
                    $display("FAIL div_add_resp: got rv=%b d=%h id=%h f=%h want 1/00000005/020/00", rv, rdata, rid, rflag);
                end
            end else if (rv !== 1'b0) begin
                nerr++;
                $display("FAIL div_idle c%0d: rv got %b want 0", c, rv);
            end
            if (c == DIVLAT) add_done = 1;
            nxt();
        end
    endtask

    task automatic test_div_zero;
        do_reset();
        for (int c = 0; c < 36; c++) begin
            if (c == 0) drive(1'b1, 5'd5, 32'd9, 32'd0, 9'h001, '0);
            else        drive(1'b0, 5'd0, '0, '0, '0, '0);
            @(negedge clk);
            nchk++;
            if (c == DIVLAT) begin
                if (rv !== 1'b1 || rdata !== 32'hffffffff || rflag !== 6'd1 || rid !== 9'h001) begin
                    nerr++;
                    $display("FAIL divzero_resp: got rv=%b d=%h f=%h id=%h want 1/ffffffff/01/001", rv, rdata, rflag, rid);
                end
            end else if (rv !== 1'b0) begin
                nerr++;
                $display("FAIL divzero_idle c%0d: rv got %b want 0", c, rv);
            end
            nxt();
        end
    endtask

    task automatic test_illegal_order;
        do_reset();
        for (int c = 0; c < 38; c++) begin
            if (c == 0)      drive(1'b1, 5'd7, 32'd11, 32'd22, 9'h002, '0);
            else if (c == 1) drive(1'b1, 5'd0, 32'd1, 32'd1, 9'h003, '0);
            else if (c == 2) drive(1'b1, 5'd5, 32'd50, 32'd5, 9'h004, '0);
            else             drive(1'b0, 5'd0, '0, '0, '0, '0);
            @(negedge clk);
            nchk++;
            if (c == LAT) begin
                if (rv !== 1'b1 || rdata !== 32'd0 || rflag !== 6'b000110 || rid !== 9'h002) begin
                    nerr++;
                    $display("FAIL illegal_resp: got rv=%b d=%h f=%h id=%h want 1/0/06/002", rv, rdata, rflag, rid);
                end
            end else if (c == LAT + 1) begin
                if (rv !== 1'b1 || rdata !== 32'd2 || rflag !== 6'd0 || rid !== 9'h003) begin
                    nerr++;
                    $display("FAIL order_add: got rv=%b d=%h f=%h id=%h want 1/2/00/003", rv, rdata, rflag, rid);
                end
            end else if (c == 2 + DIVLAT) begin
                if (rv !== 1'b1 || rdata !== 32'd10 || rflag !== 6'd0 || rid !== 9'h004) begin
                    nerr++;
                    $display("FAIL order_div: got rv=%b d=%h f=%h id=%h want 1/a/00/004", rv, rdata, rflag, rid);
                end
            end else if (rv !== 1'b0) begin
                nerr++;
                $display("FAIL order_idle c%0d: rv got %b want 0", c, rv);
            end
            nxt();
        end
    endtask

    task automatic test_reset_mid_div;
        do_reset();
        for (int c = 0; c < 40; c++) begin
            rst_n = (c != 10);
            if (c == 0) drive(1'b1, 5'd5, 32'd1000, 32'd3, 9'h005, '0);
            else        drive(1'b0, 5'd0, '0, '0, '0, '0);
            @(negedge clk);
            if (c == 11) begin
                nchk++;
                if (gnt !== 1'b1 || rv !== 1'b0 || rid !== '0 || rdata !== '0 || rflag !== '0) begin
                    nerr++;
                    $display("FAIL midreset_state: got gnt=%b rv=%b id=%h d=%h f=%h want 1/0/0/0/0",
                             gnt, rv, rid, rdata, rflag);
                end
            end
            if (c > 11) begin
                nchk++;
                if (rv !== 1'b0) begin
                    nerr++;
                    $display("FAIL midreset_ghost c%0d: rv got %b want 0", c, rv);
                end
            end
            nxt();
        end
        rst_n = 1'b1;
    endtask

    task automatic test_random;
        logic [DW-1:0] e_d [int];
        logic [8:0]    e_id [int];
        logic [5:0]    e_f [int];
        int busy_until = -1;
        int due;
        logic [4:0] o;
        logic [DW-1:0] a, b, r;
        logic [5:0] f, fl;
        logic [8:0] i;
        logic exp_gnt, issue;
        do_reset();
        for (int c = 0; c < 460; c++) begin
            exp_gnt = (c > busy_until);
            issue = (c < 420) && exp_gnt && ($urandom_range(0, 3) != 0);
            if (issue) begin
                o = 5'($urandom_range(0, 7));
                if (o == 5'd5 && $urandom_range(0, 2) != 0) o = 5'd0;
                a = ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 20));
                b = ($urandom_range(0, 5) == 0) ? 32'd0 :
                    ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(1, 20));
                fl = 6'($urandom_range(0, 63));
                i  = 9'($urandom_range(0, 511));
                ref_op(o, a, b, fl[0], r, f);
                due = (o == 5'd5) ? c + DIVLAT : c + LAT;
                if (o == 5'd5) busy_until = c + DW;
                nchk++;
                if (e_d.exists(due)) begin
                    nerr++;
                    $display("FAIL rand_double_completion c%0d: two responses due, want one", due);
                end
                e_d[due] = r; e_id[due] = i; e_f[due] = f;
                drive(1'b1, o, a, b, i, fl);
            end else begin
                drive(1'b0, 5'd0, '0, '0, '0, '0);
            end
            @(negedge clk);
            nchk++;
            if (gnt !== exp_gnt) begin
                nerr++;
                $display("FAIL rand_gnt c%0d: got %b want %b", c, gnt, exp_gnt);
            end
            nchk++;
            if (e_d.exists(c)) begin
                if (rv !== 1'b1 || rdata !== e_d[c] || rid !== e_id[c] || rflag !== e_f[c]) begin
                    nerr++;
                    $display("FAIL rand_resp c%0d: got rv=%b d=%h id=%h f=%h want 1/%h/%h/%h",
                             c, rv, rdata, rid, rflag, e_d[c], e_id[c], e_f[c]);
                end
            end else if (rv !== 1'b0 || rdata !== '0 || rid !== '0 || rflag !== '0) begin
                nerr++;
                $display("FAIL rand_idle c%0d: got rv=%b d=%h id=%h f=%h want all 0", c, rv, rdata, rid, rflag);
            end
            nxt();
        end
    endtask

    initial begin
        rst_n = 1'b0;
        drive(1'b0, 5'd0, '0, '0, '0, '0);
        #1;
        test_reset();
        test_add();
        test_back_to_back();
        test_div_stall();
        test_div_zero();
        test_illegal_order();
        test_reset_mid_div();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end
endmodule
